dmem_arbiter: RTL
=================

# dmem_arbiter

Sequencing controller for the single-port data memory array shared by the pipeline MEM stage (CPU port) and a debug/loader port (DBG port). It arbitrates between the two requesters with round-robin priority and converts byte addresses to word indices. It drives one memory command at a time with a fixed read latency and returns completion and error status. The CPU port produces a combinational stall that freezes PC, IF/ID and downstream pipeline registers until the access completes.

## Interface
- `LAT`, 2: memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..7.
- `WORDS`, 1024: number of 64-bit words in the memory array.
- `IDX_W`, 10: word index width; must equal clog2(`WORDS`).
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request; held with fields stable until `cpu_done`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 64: byte address.
- `cpu_wdata` in 64: store data.
- `cpu_stall` out 1: `cpu_req & ~cpu_done` (combinational).
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_done`; access was misaligned or out of range.
- `cpu_rdata` out 64: load data; valid from `cpu_done`, held until the next CPU completion.
- `dbg_req`, `dbg_we`, `dbg_addr`(64), `dbg_wdata`(64) in: same semantics as the CPU port.
- `dbg_done`, `dbg_err` out 1; `dbg_rdata` out 64: same semantics as the CPU port.
- `mem_en` out 1: memory command strobe, one cycle per access.
- `mem_we` out 1: write enable, qualified by `mem_en`.
- `mem_index` out IDX_W: word index.
- `mem_wdata` out 64: write data.
- `mem_rdata` in 64: read data, valid exactly LAT cycles after the `mem_en` cycle.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Address check is done in IDLE on the granted request. The access is valid iff addr[2:0]==0 and addr[63:3] < WORDS. Index = addr[IDX_W+2:3].
- IDLE: if any request is pending, grant one and latch owner, we, index, wdata and the valid flag.
  - Next state is ISSUE if valid, DONE with err=1 if invalid.
  - No request pending: stay in IDLE.
- Arbitration: only one requester pending → it wins. Both pending → the one not granted last wins (`last_grant` toggles fairness). `last_grant` updates on every grant, including erroring grants.
- ISSUE: `mem_en`=1, `mem_we`=latched we, `mem_index`/`mem_wdata` from latches. Write → DONE. Read → WAIT with counter = LAT.
- WAIT: counter decrements each cycle. In the cycle where counter==1, `mem_rdata` is captured into the owner's rdata register at the clock edge, and the next state is DONE.
- DONE: the owner's done pulse is asserted, with its err flag. Next state is always IDLE; requests are not sampled in DONE.
- Errored read: owner rdata is set to 0 and no memory command is issued. Errored write has no memory effect.
- Non-owner outputs are unaffected by an access.
- `mem_index` and `mem_wdata` hold their last value outside ISSUE. `mem_we`=0 whenever `mem_en`=0.

## Timing
- Request first seen in IDLE at cycle c0:
  - valid read: `mem_en` at c0+1, `mem_rdata` sampled at the end of c0+1+LAT, done at c0+2+LAT.
  - valid write: `mem_en`+`mem_we` at c0+1, done at c0+2.
  - invalid access: done+err at c0+1, no `mem_en`.
- Requester drops or changes its request in the cycle after done. That cycle is IDLE, so back-to-back CPU accesses run with no bubble beyond IDLE.
- `cpu_stall` is high from c0 through the cycle before `cpu_done`, and low in the done cycle so the pipeline advances on that edge.
- Reset (any state, including ISSUE/WAIT):
  - next cycle is IDLE; `last_grant`=DBG, so the CPU wins the first tie.
  - the in-flight read is discarded, with no done pulse.
  - a write already issued in ISSUE is not undone.
- Output reset values: `mem_en` 0, `mem_we` 0, `mem_index` 0, `mem_wdata` 0, all done/err 0, `cpu_rdata` 0, `dbg_rdata` 0.
- `cpu_stall` follows `cpu_req` during reset.
- A request arriving while busy waits in IDLE arbitration. There is no queueing; the held request is the queue entry.

## Test plan
- LAT=2, mem word 1 = 0x1F; CPU load addr 0x8 at c0 → `mem_en`, `mem_index`=1 at c1; `cpu_done` at c4; `cpu_rdata`=0x1F; `cpu_stall` high c0–c3, low c4.
- CPU store addr 0x10 data 0xAB at c0 → `mem_en`=`mem_we`=1, index 2, `mem_wdata` 0xAB at c1; `cpu_done` at c2; DBG load of 0x10 then returns 0xAB.
- After reset, both ports hold load requests continuously → grant order CPU, DBG, CPU, DBG; each done pulse goes to the correct port only.
- CPU load addr 0x4, then addr 0x2000 → each gets `cpu_done`+`cpu_err` one cycle after request, `cpu_rdata`=0, and no `mem_en` pulse.
- DBG load issued, then reset asserted in the WAIT cycle → IDLE next cycle, no `dbg_done`, all outputs at reset values; next CPU request completes normally.
- LAT=1 build: CPU load at c0 → done at c3; two back-to-back CPU stores → `mem_en` at c1 and c4.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the CPU port, the debug/loader port and the memory command
//   port of the data-memory arbiter.
//
//   Handshake (both requester ports): the requester raises *_req with
//   *_we/*_addr/*_wdata stable and holds them until it sees the one-cycle
//   *_done pulse. *_err is meaningful only while *_done is high. *_rdata
//   is valid from *_done and holds until that port's next completion.
//   The requester drops or changes its request in the cycle after *_done.
//
//   Modports:
//     slave  - the arbiter (takes requests, drives the memory command)
//     master - the requesters and the memory array
interface dmem_arbiter_if #(
    parameter int IDX_W = 10
);
    logic             cpu_req;
    logic             cpu_we;
    logic [63:0]      cpu_addr;
    logic [63:0]      cpu_wdata;
    logic             cpu_stall;
    logic             cpu_done;
    logic             cpu_err;
    logic [63:0]      cpu_rdata;

    logic             dbg_req;
    logic             dbg_we;
    logic [63:0]      dbg_addr;
    logic [63:0]      dbg_wdata;
    logic             dbg_done;
    logic             dbg_err;
    logic [63:0]      dbg_rdata;

    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_index;
    logic [63:0]      mem_wdata;
    logic [63:0]      mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_done, cpu_err, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_done, dbg_err, dbg_rdata,
        output mem_en, mem_we, mem_index, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_done, cpu_err, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_done, dbg_err, dbg_rdata,
        input  mem_en, mem_we, mem_index, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Sequences the single-port data memory between the pipeline MEM stage
//   (CPU port) and the debug/loader port (DBG port). Round-robin grant,
//   byte address -> word index conversion, one memory command at a time,
//   fixed read latency LAT, completion and error status per port.
//
//   Ports:
//     clock, reset - rising-edge clock, synchronous active-high reset
//     bus          - dmem_arbiter_if.slave (CPU, DBG and memory signals)
//     fsm_state    - current controller state for observation
//                    (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
module dmem_arbiter #(
    parameter int LAT   = 2,
    parameter int WORDS = 1024,
    parameter int IDX_W = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           fsm_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [63:0]      cpu_rdata_q, cpu_rdata_d;
    logic [63:0]      dbg_rdata_q, dbg_rdata_d;

    logic             grant_dbg;
    logic             sel_we;
    logic             sel_ok;
    logic [63:0]      sel_addr;
    logic [63:0]      sel_wdata;

    // DBG wins when it is alone, or on a tie when CPU had the last grant.
    always_comb begin
        grant_dbg = bus.dbg_req & (~bus.cpu_req | (last_grant_q == OWN_CPU));
        sel_we    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
        sel_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
        sel_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        sel_ok    = (sel_addr[2:0] == 3'b000) &&
                    ({3'b000, sel_addr[63:3]} < 64'(WORDS));
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        err_d        = err_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    owner_d      = grant_dbg;
                    last_grant_d = grant_dbg;
                    we_d         = sel_we;
                    err_d        = ~sel_ok;
                    if (sel_ok) begin
                        // idx/wdata double as the memory command outputs, so
                        // they only move on a grant that will really issue.
                        idx_d   = sel_addr[IDX_W+2:3];
                        wdata_d = sel_wdata;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                        if (!sel_we) begin
                            if (grant_dbg) dbg_rdata_d = '0;
                            else           cpu_rdata_d = '0;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(LAT);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (owner_q == OWN_DBG) dbg_rdata_d = bus.mem_rdata;
                    else                    cpu_rdata_d = bus.mem_rdata;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DBG;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign bus.mem_en    = (state_q == S_ISSUE);
    assign bus.mem_we    = (state_q == S_ISSUE) & we_q;
    assign bus.mem_index = idx_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.cpu_done  = (state_q == S_DONE) & (owner_q == OWN_CPU);
    assign bus.dbg_done  = (state_q == S_DONE) & (owner_q == OWN_DBG);
    assign bus.cpu_err   = bus.cpu_done & err_q;
    assign bus.dbg_err   = bus.dbg_done & err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;

    // Low in the done cycle so the pipeline advances on that edge.
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

    assign fsm_state = state_q;
endmodule
